param_updown_counter: RTL

Parametrised synchronous modulo-N up/down counter with synchronous load, selectable wrap/saturate behaviour and cascadable terminal-count outputs. It is the next-generation replacement for the team's fixed 4-bit enable-gated binary counter. It is used directly for event counting and chained for wider dividers and timers.

---
 rtl/counter_pkg.sv | 13 +
 rtl/count_next.sv | 47 ++++
 rtl/param_updown_counter.sv | 59 +++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
package counter_pkg;

    // Count direction encoding on up_dn.
    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

    // Clamp an out-of-range load value to the highest legal count (modulus - 1).
    function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] modulus);
        return (d >= modulus) ? (modulus - 32'd1) : d;
    endfunction

endpackage

// File: rtl/count_next.sv
// Next-count logic: one step up/down with wrap or saturate at the terminal value.
// Compares against the terminal value before stepping so nothing relies on overflow.
module count_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             wrap_en,
    input  logic             count_enable,
    output logic [WIDTH-1:0] q_next,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TERM_MAX = WIDTH'(MODULUS - 1);

    logic at_max;
    logic at_min;

    // Terminal detect and next value; hold is the default.
    always_comb begin
        at_max = (q == TERM_MAX);
        at_min = (q == '0);
        tc     = (up_dn == CNT_UP) ? at_max : at_min;
        q_next = q;
        if (count_enable) begin
            if (up_dn == CNT_UP) begin
                if (!at_max) begin
                    q_next = q + WIDTH'(1);
                end else if (wrap_en) begin
                    q_next = '0;
                end
            end else begin
                if (!at_min) begin
                    q_next = q - WIDTH'(1);
                end else if (wrap_en) begin
                    q_next = TERM_MAX;
                end
            end
        end
        wrap = count_enable & wrap_en & tc;
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo-N up/down counter with synchronous clear/load and cascade output.
// Chain stages by driving the next stage's count_enable from carry_out.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             count_enable,
    input  logic             up_dn,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out
);

    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] load_val;
    logic             wrap;

    count_next #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_count_next (
        .q           (q),
        .up_dn       (up_dn),
        .wrap_en     (wrap_en),
        .count_enable(count_enable),
        .q_next      (q_step),
        .tc          (tc),
        .wrap        (wrap)
    );

    assign load_val = WIDTH'(clamp_load(32'(d), 32'(MODULUS)));

    // Only a real wrap propagates; clear and load suppress the step.
    assign carry_out = wrap & ~load & ~cl;

    // Priority mux: clear over load over count/hold.
    always_comb begin
        q_d = q_step;
        if (cl) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_val;
        end
    end

    // Count register; clear is the synchronous reset.
    always_ff @(posedge clk) begin
        q <= q_d;
    end

endmodule
